// File: rtl/morse_level_profile_ctrl.sv
// Level-profile controller: level browse/commit, sequential unit calculator, demo-player pacing, servo angle.
// Optional build macro LEVEL_WRAP_EN: up/dn wrap around at the level ends instead of saturating.
module morse_level_profile_ctrl #(
    parameter int unsigned NUM_LEVELS  = 4,
    parameter int unsigned LW          = 4,
    parameter int unsigned BASE_UNIT   = 250_000,
    parameter int unsigned RESTART_DLY = 2_500_000,
    parameter int unsigned SERVO_MAX   = 180
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ui_active,
    input  logic          btn_up,
    input  logic          btn_dn,
    input  logic          btn_commit,
    input  logic          ext_set,
    input  logic [LW-1:0] ext_level,
    input  logic          player_done,
    output logic          player_start,
    output logic [LW-1:0] level_idx,
    output logic [LW-1:0] saved_idx,
    output logic          text_valid,
    output logic          calc_busy,
    output logic [31:0]   unit_cycles,
    output logic [31:0]   dit_time,
    output logic [31:0]   dah_time,
    output logic [31:0]   dit_gap,
    output logic [31:0]   long_key,
    output logic [31:0]   timeout_cyc,
    output logic [31:0]   space_cyc,
    output logic          settings_applied,
    output logic [8:0]    servo_angle,
    output logic [1:0]    play_state
);

    localparam int unsigned SW = LW + 1;
    localparam int unsigned AW = 32 + SW;
    localparam logic [LW-1:0] TOP = LW'(NUM_LEVELS - 1);
    localparam int unsigned STEP = SERVO_MAX / (NUM_LEVELS - 1);

    function automatic logic [31:0] sat(input logic [63:0] v);
        return (|v[63:32]) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    function automatic logic [31:0] scale_unit(input logic [31:0] u, input logic [3:0] k);
        logic [63:0] w;
        logic [63:0] s;
        w = {32'd0, u};
        s = '0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) s = s + (w << i);
        end
        return sat(s);
    endfunction

    localparam logic [31:0] UNIT0 = sat(64'(BASE_UNIT) * 64'(NUM_LEVELS));

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PLAY} play_state_e;

    logic [LW-1:0] level_q, level_d, saved_q, saved_d, ext_clamp;
    logic          uiact_q, rise, level_evt, commit_req, apply;
    logic          text_valid_q, busy_q, busy_d, pend_q, pend_d, applied_q;
    logic [AW-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_next;
    logic [SW-1:0] mplier_q, mplier_d, bit_q, bit_d;
    logic [31:0]   unit_q, unit_d;
    logic [31:0]   dit_q, dah_q, gap_q, long_q, tmo_q, space_q;
    play_state_e   state_q, state_d;
    logic [31:0]   wcnt_q, wcnt_d;
    logic          start_q, start_d;

    always_comb begin
        ext_clamp  = (ext_level > TOP) ? TOP : ext_level;
        rise       = ui_active & ~uiact_q;
        level_d    = level_q;
        saved_d    = saved_q;
        commit_req = 1'b0;
        if (ext_set) saved_d = ext_clamp;
        if (rise) begin
            level_d = ext_set ? ext_clamp : saved_q;
        end else if (ui_active) begin
            if (ext_set) begin
                level_d = ext_clamp;
            end else if (btn_commit) begin
                commit_req = 1'b1;
                saved_d    = level_q;
            end else if (btn_up) begin
                if (level_q != TOP) level_d = level_q + LW'(1);
`ifdef LEVEL_WRAP_EN
                else level_d = '0;
`endif
            end else if (btn_dn) begin
                if (level_q != '0) level_d = level_q - LW'(1);
`ifdef LEVEL_WRAP_EN
                else level_d = TOP;
`endif
            end
        end
        level_evt = rise | (level_d != level_q);
    end

    // LSB-first shift-add: one multiplier bit per cycle, result lands after SW bits.
    always_comb begin
        busy_d   = busy_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        bit_d    = bit_q;
        unit_d   = unit_q;
        acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        if (level_evt) begin
            busy_d   = 1'b1;
            mcand_d  = AW'(BASE_UNIT);
            mplier_d = SW'(NUM_LEVELS) - SW'(level_d);
            acc_d    = '0;
            bit_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            bit_d    = bit_q + SW'(1);
            if (bit_q == SW'(LW)) begin
                busy_d = 1'b0;
                unit_d = sat(64'(acc_next));
            end
        end
    end

    // A commit seen while busy waits until the calculator is idle, so it uses the fresh unit.
    always_comb begin
        apply  = ~busy_q & (commit_req | pend_q);
        pend_d = pend_q;
        if (apply) pend_d = 1'b0;
        else if (commit_req) pend_d = 1'b1;
    end

    // player_start: one-cycle request; player_done: one-cycle completion, no back-pressure.
    // In PLAY each done re-arms the next start; any level event returns to WAIT.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        start_d = 1'b0;
        if (!ui_active) begin
            state_d = S_IDLE;
        end else if (level_evt) begin
            state_d = S_WAIT;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (!busy_q) begin
                        if (wcnt_q == 32'(RESTART_DLY - 1)) begin
                            state_d = S_PLAY;
                            start_d = 1'b1;
                            wcnt_d  = '0;
                        end else begin
                            wcnt_d = wcnt_q + 32'd1;
                        end
                    end
                end
                S_PLAY:  if (player_done) start_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q      <= '0;
            saved_q      <= '0;
            uiact_q      <= 1'b0;
            text_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            bit_q        <= '0;
            unit_q       <= UNIT0;
            pend_q       <= 1'b0;
            applied_q    <= 1'b0;
            dit_q        <= UNIT0;
            dah_q        <= scale_unit(UNIT0, 4'd3);
            gap_q        <= UNIT0;
            long_q       <= scale_unit(UNIT0, 4'd2);
            tmo_q        <= scale_unit(UNIT0, 4'd6);
            space_q      <= scale_unit(UNIT0, 4'd12);
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            start_q      <= 1'b0;
        end else begin
            level_q      <= level_d;
            saved_q      <= saved_d;
            uiact_q      <= ui_active;
            text_valid_q <= level_evt;
            busy_q       <= busy_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            bit_q        <= bit_d;
            unit_q       <= unit_d;
            pend_q       <= pend_d;
            applied_q    <= apply;
            if (apply) begin
                dit_q   <= unit_q;
                dah_q   <= scale_unit(unit_q, 4'd3);
                gap_q   <= unit_q;
                long_q  <= scale_unit(unit_q, 4'd2);
                tmo_q   <= scale_unit(unit_q, 4'd6);
                space_q <= scale_unit(unit_q, 4'd12);
            end
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            start_q      <= start_d;
        end
    end

    assign level_idx        = level_q;
    assign saved_idx        = saved_q;
    assign text_valid       = text_valid_q;
    assign calc_busy        = busy_q;
    assign unit_cycles      = unit_q;
    assign dit_time         = dit_q;
    assign dah_time         = dah_q;
    assign dit_gap          = gap_q;
    assign long_key         = long_q;
    assign timeout_cyc      = tmo_q;
    assign space_cyc        = space_q;
    assign settings_applied = applied_q;
    assign player_start     = start_q;
    assign play_state       = state_q;
    assign servo_angle      = (level_q == TOP) ? 9'(SERVO_MAX) : (9'(level_q) * 9'(STEP));

endmodule

// File: tb/tb_morse_level_profile_ctrl.sv
// Directed bench for morse_level_profile_ctrl (NUM_LEVELS=4, BASE_UNIT=250_000, short restart delay).
module tb_morse_level_profile_ctrl;

    localparam int LW  = 4;
    localparam int DLY = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ui_active, btn_up, btn_dn, btn_commit, ext_set, player_done;
    logic [LW-1:0] ext_level;
    logic          player_start, text_valid, calc_busy, settings_applied;
    logic [LW-1:0] level_idx, saved_idx;
    logic [31:0]   unit_cycles, dit_time, dah_time, dit_gap, long_key, timeout_cyc, space_cyc;
    logic [8:0]    servo_angle;
    logic [1:0]    play_state;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    morse_level_profile_ctrl #(
        .NUM_LEVELS(4), .LW(LW), .BASE_UNIT(250_000), .RESTART_DLY(DLY), .SERVO_MAX(180)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ui_active(ui_active), .btn_up(btn_up), .btn_dn(btn_dn),
        .btn_commit(btn_commit), .ext_set(ext_set), .ext_level(ext_level),
        .player_done(player_done), .player_start(player_start), .level_idx(level_idx),
        .saved_idx(saved_idx), .text_valid(text_valid), .calc_busy(calc_busy),
        .unit_cycles(unit_cycles), .dit_time(dit_time), .dah_time(dah_time), .dit_gap(dit_gap),
        .long_key(long_key), .timeout_cyc(timeout_cyc), .space_cyc(space_cyc),
        .settings_applied(settings_applied), .servo_angle(servo_angle), .play_state(play_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"}, 32'(level_idx), 0);
        check({tag, "_saved"}, 32'(saved_idx), 0);
        check({tag, "_unit"}, unit_cycles, 1_000_000);
        check({tag, "_dit"}, dit_time, 1_000_000);
        check({tag, "_dah"}, dah_time, 3_000_000);
        check({tag, "_space"}, space_cyc, 12_000_000);
        check({tag, "_busy"}, 32'(calc_busy), 0);
        check({tag, "_applied"}, 32'(settings_applied), 0);
        check({tag, "_tv"}, 32'(text_valid), 0);
        check({tag, "_start"}, 32'(player_start), 0);
        check({tag, "_servo"}, 32'(servo_angle), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ui_active = 0; btn_up = 0; btn_dn = 0; btn_commit = 0;
        ext_set = 0; ext_level = '0; player_done = 0;
        repeat (3) step();
        check_reset_state("rst");
        check("rst_gap", dit_gap, 1_000_000);
        check("rst_long", long_key, 2_000_000);
        check("rst_tmo", timeout_cyc, 6_000_000);
        rst_n = 1'b1;
        step();

        // activation, two ups, commit while the calculator runs
        ui_active = 1; step();
        check("act_tv", 32'(text_valid), 1);
        check("act_busy", 32'(calc_busy), 1);
        btn_up = 1; step();
        check("up1_level", 32'(level_idx), 1);
        check("up1_tv", 32'(text_valid), 1);
        step();
        check("up2_level", 32'(level_idx), 2);
        check("up2_tv", 32'(text_valid), 1);
        btn_up = 0; btn_commit = 1; step();
        btn_commit = 0;
        check("cm_saved", 32'(saved_idx), 2);
        check("cm_tv", 32'(text_valid), 0);
        check("cm_busy", 32'(calc_busy), 1);
        check("cm_applied_early", 32'(settings_applied), 0);
        repeat (3) step();
        check("calc_busy_e4", 32'(calc_busy), 1);
        check("calc_unit_e4", unit_cycles, 1_000_000);
        step();
        check("calc_busy_e5", 32'(calc_busy), 0);
        check("calc_unit_e5", unit_cycles, 500_000);
        check("calc_applied_e5", 32'(settings_applied), 0);
        check("servo_l2", 32'(servo_angle), 120);
        step();
        check("apply_pulse", 32'(settings_applied), 1);
        check("apply_dit", dit_time, 500_000);
        check("apply_dah", dah_time, 1_500_000);
        check("apply_gap", dit_gap, 500_000);
        check("apply_long", long_key, 1_000_000);
        check("apply_tmo", timeout_cyc, 3_000_000);
        check("apply_space", space_cyc, 6_000_000);
        step();
        check("apply_pulse_end", 32'(settings_applied), 0);

        // playback: restart delay counted from the end of the calculation
        cnt = 0;
        for (int i = 8; i <= 24; i++) begin
            step();
            if (player_start) cnt++;
        end
        check("play_early_starts", 32'(cnt), 0);
        step();
        check("play_start", 32'(player_start), 1);
        step();
        check("play_start_end", 32'(player_start), 0);
        player_done = 1; step();
        player_done = 0;
        check("play_loop_start", 32'(player_start), 1);
        step();
        check("play_loop_end", 32'(player_start), 0);

        // level change in PLAY restarts the delay
        btn_up = 1; step();
        btn_up = 0;
        check("play_up_level", 32'(level_idx), 3);
        check("play_up_tv", 32'(text_valid), 1);
        check("play_up_start", 32'(player_start), 0);
        check("servo_top", 32'(servo_angle), 180);
        cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            player_done = (i == 3);
            step();
            if (player_start) cnt++;
        end
        player_done = 0;
        check("replay_early_starts", 32'(cnt), 0);
        check("replay_unit", unit_cycles, 250_000);
        step();
        check("replay_start", 32'(player_start), 1);

        // done and level change together: level change wins
        player_done = 1; btn_dn = 1; step();
        player_done = 0; btn_dn = 0;
        check("simul_level", 32'(level_idx), 2);
        check("simul_tv", 32'(text_valid), 1);
        check("simul_start", 32'(player_start), 0);

        // top/bottom bounds
        btn_up = 1; step();
        check("bnd_up_level", 32'(level_idx), 3);
        step();
        btn_up = 0;
`ifdef LEVEL_WRAP_EN
        check("bnd_top_level", 32'(level_idx), 0);
        check("bnd_top_tv", 32'(text_valid), 1);
`else
        check("bnd_top_level", 32'(level_idx), 3);
        check("bnd_top_tv", 32'(text_valid), 0);
`endif
        ext_set = 1; ext_level = 4'd0; step();
        ext_set = 0;
        check("ext0_level", 32'(level_idx), 0);
        check("ext0_saved", 32'(saved_idx), 0);
        btn_dn = 1; step();
        btn_dn = 0;
`ifdef LEVEL_WRAP_EN
        check("bnd_bot_level", 32'(level_idx), 3);
        check("bnd_bot_tv", 32'(text_valid), 1);
`else
        check("bnd_bot_level", 32'(level_idx), 0);
        check("bnd_bot_tv", 32'(text_valid), 0);
`endif
        ext_set = 1; ext_level = 4'd1; step();
        ext_set = 0;
        check("ext1_level", 32'(level_idx), 1);
        check("ext1_saved", 32'(saved_idx), 1);
        check("ext1_tv", 32'(text_valid), 1);

        // inactive: ext_set clamps into saved_idx only, buttons ignored, no playback
        ui_active = 0; step();
        ext_set = 1; ext_level = 4'd7; step();
        ext_set = 0;
        check("inact_ext_saved", 32'(saved_idx), 3);
        check("inact_ext_level", 32'(level_idx), 1);
        btn_up = 1; step();
        btn_up = 0;
        check("inact_up_level", 32'(level_idx), 1);
        check("inact_up_tv", 32'(text_valid), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (player_start) cnt++;
        end
        check("inact_starts", 32'(cnt), 0);
        ui_active = 1; step();
        check("react_level", 32'(level_idx), 3);
        check("react_tv", 32'(text_valid), 1);
        check("react_servo", 32'(servo_angle), 180);

        // reset mid-calculation with a pending commit
        btn_commit = 1; step();
        btn_commit = 0;
        check("pend_busy", 32'(calc_busy), 1);
        step();
        rst_n = 0;
        #1;
        check_reset_state("midrst");
        ui_active = 0;
        step();
        rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (settings_applied) cnt++;
        end
        check("post_rst_applied", 32'(cnt), 0);
        check("post_rst_dit", dit_time, 1_000_000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
